// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: issues one imem read per PC over req/ack and holds the word for decode.
// Optional misaligned-PC check is enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] npc_i,
   input  logic              stall_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [31:0]       imem_rdata_i,
   output logic [ADDR_W-1:0] pc_f_o,
   output logic [31:0]       instr_f_o,
   output logic              f_valid_o,
   output logic [31:0]       fetch_cnt_o,
   output logic              addr_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_t;

   state_t            state_q, state_nxt;
   logic              req_q, req_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [31:0]       instr_q, instr_nxt;
   logic              valid_q, valid_nxt;
   logic [31:0]       cnt_q, cnt_nxt;
   logic              err_nxt;

   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return {pc[ADDR_W-1:2], 2'b00};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      req_nxt   = req_q;
      pc_nxt    = pc_q;
      instr_nxt = instr_q;
      valid_nxt = valid_q;
      cnt_nxt   = cnt_q;
      err_nxt   = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_nxt = S_WAIT;
            req_nxt   = 1'b1;
         end
         S_WAIT: begin
            if (imem_ack_i) begin
               instr_nxt = imem_rdata_i;
               valid_nxt = 1'b1;
               req_nxt   = 1'b0;
               state_nxt = S_VALID;
            end
         end
         S_VALID: begin
            // npc_i is only looked at on the cycle decode takes the held word
            if (!stall_i) begin
`ifdef FETCH_ALIGN_CHK_EN
               pc_nxt  = align_pc(npc_i);
               err_nxt = (npc_i[1:0] != 2'b00);
`else
               pc_nxt  = npc_i;
`endif
               cnt_nxt   = cnt_q + 32'd1;
               valid_nxt = 1'b0;
               req_nxt   = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q   <= 1'b0;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         req_q   <= req_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
         valid_q <= valid_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

`ifdef FETCH_ALIGN_CHK_EN
   logic err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_nxt;
      end
   end

   assign addr_err_o = err_q;
`else
   logic unused_align;
   assign unused_align = err_nxt ^ (|align_pc(pc_q));
   assign addr_err_o   = 1'b0;
`endif

   assign imem_req_o  = req_q;
   assign imem_addr_o = pc_q;
   assign pc_f_o      = pc_q;
   assign instr_f_o   = instr_q;
   assign f_valid_o   = valid_q;
   assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table of consumptions driven against a latency-programmable memory model,
// plus hand sequences for reset-time behaviour; expected fetches tracked in a scoreboard queue.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] npc_i;
   logic        stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_f_o;
   logic [31:0] instr_f_o;
   logic        f_valid_o;
   logic [31:0] fetch_cnt_o;
   logic        addr_err_o;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .npc_i(npc_i), .stall_i(stall_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
      .pc_f_o(pc_f_o), .instr_f_o(instr_f_o), .f_valid_o(f_valid_o),
      .fetch_cnt_o(fetch_cnt_o), .addr_err_o(addr_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] npc;
      int          stall_cyc;
      int          lat;
      logic        spur;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[6];
   int          checks = 0;
   int          failures = 0;
   int          lat = 1;
   logic        spur = 1'b0;
   int          wcnt = 0;
   logic [31:0] exp_addr;
   logic [31:0] exp_cnt;
   exp_t        cur;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] model_pc(input logic [31:0] n);
`ifdef FETCH_ALIGN_CHK_EN
      return {n[31:2], 2'b00};
`else
      return n;
`endif
   endfunction

   function automatic logic model_err(input logic [31:0] n);
`ifdef FETCH_ALIGN_CHK_EN
      return (n[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One clock: memory model updates just after the edge, address stability checked while requesting.
   task automatic tick();
      @(posedge clk);
      #1;
      if (imem_req_o) begin
         imem_ack_i   = (wcnt >= lat);
         imem_rdata_i = mem_word(imem_addr_o);
         wcnt++;
         chk("imem_addr", imem_addr_o, exp_addr);
      end else begin
         wcnt         = 0;
         imem_ack_i   = spur;
         imem_rdata_i = spur ? 32'hDEAD_BEEF : 32'h0;
      end
      #3;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!f_valid_o && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (!f_valid_o) begin
         failures++;
         $display("FAIL wait_valid actual=timeout expected=f_valid_o");
      end
   endtask

   task automatic pop_check(input string tag);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_scoreboard actual=empty expected=entry", tag);
      end else begin
         cur = sb.pop_front();
         chk({tag, "_pc"}, pc_f_o, cur.pc);
         chk({tag, "_instr"}, instr_f_o, cur.instr);
         chk({tag, "_cnt"}, fetch_cnt_o, exp_cnt);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pc"}, pc_f_o, RST_PC);
      chk({tag, "_instr"}, instr_f_o, 32'h0);
      chk({tag, "_valid"}, {31'd0, f_valid_o}, 32'd0);
      chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
      chk({tag, "_cnt"}, fetch_cnt_o, 32'h0);
      chk({tag, "_err"}, {31'd0, addr_err_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{32'h0000_3004, 0, 0, 1'b0};
      tbl[1] = '{32'h0000_3008, 0, 0, 1'b0};
      tbl[2] = '{32'h0000_300C, 5, 4, 1'b1};
      tbl[3] = '{32'h0000_3012, 0, 1, 1'b0};
      tbl[4] = '{32'h0000_3020, 2, 0, 1'b1};
      tbl[5] = '{32'hFFFF_FFF0, 1, 2, 1'b0};

      reset = 1'b1; npc_i = 32'h0; stall_i = 1'b0;
      imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
      exp_addr = RST_PC; exp_cnt = 32'd0;
      tick(); tick();
      check_reset_vals("rst");

      // Release: req in cycle 1, 1-cycle ack, word valid in cycle 3
      reset = 1'b0;
      lat = 1;
      sb.push_back('{RST_PC, mem_word(RST_PC)});
      tick();
      chk("c1_req", {31'd0, imem_req_o}, 32'd1);
      chk("c1_valid", {31'd0, f_valid_o}, 32'd0);
      tick();
      chk("c2_valid", {31'd0, f_valid_o}, 32'd0);
      tick();
      chk("c3_valid", {31'd0, f_valid_o}, 32'd1);
      chk("c3_req", {31'd0, imem_req_o}, 32'd0);
      pop_check("first");

      for (int i = 0; i < 6; i++) begin
         for (int s = 0; s < tbl[i].stall_cyc; s++) begin
            stall_i = 1'b1;
            npc_i   = $urandom;
            spur    = tbl[i].spur;
            tick();
            chk("stall_pc", pc_f_o, cur.pc);
            chk("stall_instr", instr_f_o, cur.instr);
            chk("stall_valid", {31'd0, f_valid_o}, 32'd1);
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
         end
         spur     = 1'b0;
         stall_i  = 1'b0;
         npc_i    = tbl[i].npc;
         lat      = tbl[i].lat;
         exp_addr = model_pc(tbl[i].npc);
         sb.push_back('{model_pc(tbl[i].npc), mem_word(model_pc(tbl[i].npc))});
         tick();
         exp_cnt = exp_cnt + 32'd1;
         chk("cons_valid", {31'd0, f_valid_o}, 32'd0);
         chk("cons_req", {31'd0, imem_req_o}, 32'd1);
         chk("cons_cnt", fetch_cnt_o, exp_cnt);
         chk("cons_err", {31'd0, addr_err_o}, {31'd0, model_err(tbl[i].npc)});
         npc_i = $urandom;
         tick();
         chk("err_clear", {31'd0, addr_err_o}, 32'd0);
         wait_valid();
         pop_check("vec");
      end

      // Reset while waiting on a slow memory; a late ack must not leak through
      stall_i  = 1'b0;
      npc_i    = 32'h0000_4000;
      lat      = 10;
      exp_addr = 32'h0000_4000;
      tick();
      tick();
      chk("midwait_req", {31'd0, imem_req_o}, 32'd1);
      reset = 1'b1;
      #1;
      check_reset_vals("async_rst");
      spur = 1'b1;
      tick();
      check_reset_vals("late_ack");
      reset = 1'b0;
      spur  = 1'b0;
      lat   = 1;
      exp_addr = RST_PC;
      exp_cnt  = 32'd0;
      sb.delete();
      sb.push_back('{RST_PC, mem_word(RST_PC)});
      tick();
      chk("rerun_req", {31'd0, imem_req_o}, 32'd1);
      chk("rerun_valid", {31'd0, f_valid_o}, 32'd0);
      wait_valid();
      pop_check("rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
